// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencing/configuration controller.
//   NUM_TAPS, DATA_W, OUT_W, LATENCY, OBUF_DEPTH : default datapath geometry
//   coeff_t       : one Q31 coefficient
//   ctrl_state_e  : controller states RUN / DRAIN / SWAP
//   tap_in_range  : coefficient-address range check
package fir_pkg;

  localparam int NUM_TAPS   = 102;
  localparam int DATA_W     = 32;
  localparam int OUT_W      = 64;
  localparam int LATENCY    = 2;
  localparam int OBUF_DEPTH = 4;

  typedef logic signed [DATA_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } ctrl_state_e;

  function automatic logic tap_in_range(input int unsigned addr, input int unsigned num_taps);
    return (addr < num_taps);
  endfunction

endpackage

// File: rtl/fir_ctrl_if.sv
// fir_ctrl_if: valid/ready stream bundle used for both the sample input and
// the result output of fir_ctrl.
//   valid : producer has data this cycle
//   ready : consumer takes data this cycle when valid is also high
//   data  : payload, W bits
// Modports: master drives valid/data, slave drives ready.
interface fir_ctrl_if #(
  parameter int W = fir_pkg::DATA_W
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fir_obuf.sv
// fir_obuf: synchronous output FIFO for filter results.
//   clk, rst   : clock, asynchronous active-high reset
//   push, push_data : write one entry (accepted on full only with a same-cycle pop)
//   pop        : remove head entry (ignored when empty)
//   head       : current head entry, read straight from the storage flops
//   count      : number of stored entries
//   empty      : no entries stored
module fir_obuf #(
  parameter int DEPTH = fir_pkg::OBUF_DEPTH,
  parameter int W     = fir_pkg::OUT_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  import fir_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_s = push & (~full_s | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Occupancy update from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
    end
  end

  // Storage array; contents are only meaningful behind a valid count.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: sequencing and coefficient-bank controller for the pipelined FIR.
//   clk, rst     : clock, asynchronous active-high reset
//   s (slave)    : input sample stream (valid/ready/data)
//   m (master)   : output result stream (valid/ready/data), fed from fir_obuf
//   f_ce, f_x    : sample strobe and sample to the filter
//   f_coeff      : active coefficient bank, tap k at [k*DATA_W +: DATA_W]
//   f_y          : filter result, valid LATENCY cycles after f_ce
//   f_clr        : clear of filter partial sums (pulses in SWAP when
//                  FIR_CTRL_FLUSH_EN is defined, otherwise tied low)
//   cfg_we/cfg_addr/cfg_data : shadow coefficient write
//   cfg_commit   : request drain and swap of shadow into active bank
//   cfg_busy     : drain/swap in progress
//   cfg_err      : sticky flag for rejected writes/commits
//   sample_cnt   : accepted-sample counter
// Build option: FIR_CTRL_FLUSH_EN.
module fir_ctrl #(
  parameter int NUM_TAPS   = fir_pkg::NUM_TAPS,
  parameter int DATA_W     = fir_pkg::DATA_W,
  parameter int OUT_W      = fir_pkg::OUT_W,
  parameter int LATENCY    = fir_pkg::LATENCY,
  parameter int OBUF_DEPTH = fir_pkg::OBUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  fir_ctrl_if.slave                    s,
  fir_ctrl_if.master                   m,
  output logic                         f_ce,
  output logic [DATA_W-1:0]            f_x,
  output logic [NUM_TAPS*DATA_W-1:0]   f_coeff,
  input  logic [OUT_W-1:0]             f_y,
  output logic                         f_clr,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_TAPS)-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data,
  input  logic                         cfg_commit,
  output logic                         cfg_busy,
  output logic                         cfg_err,
  output logic [31:0]                  sample_cnt
);
  import fir_pkg::*;

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int OCC_W = CNT_W + 1;

  ctrl_state_e       state_r;
  ctrl_state_e       state_next_s;
  logic [LATENCY-1:0] tags_r;
  logic [IF_W-1:0]   inflight_s;
  logic [OCC_W-1:0]  occ_s;
  logic              ready_s;
  logic              busy_s;
  logic              swap_s;
  logic              accept_s;
  logic              tap_ok_s;
  logic              wr_ok_s;
  logic              err_set_s;
  logic              err_r;
  logic [31:0]       cnt_r;
  logic [DATA_W-1:0] shadow_r [NUM_TAPS];
  logic [DATA_W-1:0] active_r [NUM_TAPS];
  logic              push_s;
  logic              pop_s;
  logic [OUT_W-1:0]  fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;

  // Results still inside the filter plus results already buffered. Reserving
  // a FIFO slot at accept time is what guarantees nothing is ever dropped.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_s = inflight_s + IF_W'(tags_r[i]);
    end
    occ_s = OCC_W'(fifo_count_s) + OCC_W'(inflight_s);
  end

  // Next-state and per-state stream/config gating.
  always_comb begin
    state_next_s = state_r;
    ready_s      = 1'b0;
    busy_s       = 1'b1;
    swap_s       = 1'b0;
    case (state_r)
      RUN: begin
        busy_s  = 1'b0;
        ready_s = (occ_s < OCC_W'(OBUF_DEPTH));
        if (cfg_commit) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        // Checked in the same cycle, so an empty pipeline drains in one cycle.
        if (inflight_s == '0) begin
          state_next_s = SWAP;
        end else begin
          state_next_s = DRAIN;
        end
      end
      SWAP: begin
        swap_s       = 1'b1;
        state_next_s = RUN;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign accept_s = s.valid & ready_s;
  assign s.ready  = ready_s;
  assign f_ce     = accept_s;
  assign f_x      = s.data;
  assign cfg_busy = busy_s;

  // In-flight tags advance every cycle, independent of f_ce, so the tail
  // marks exactly the cycle the filter presents the matching result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_r <= '0;
    end else begin
      tags_r[0] <= accept_s;
      for (int i = 1; i < LATENCY; i++) begin
        tags_r[i] <= tags_r[i-1];
      end
    end
  end

  assign push_s = tags_r[LATENCY-1];
  assign pop_s  = ~fifo_empty_s & m.ready;

  fir_obuf #(
    .DEPTH (OBUF_DEPTH),
    .W     (OUT_W),
    .CNT_W (CNT_W)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (f_y),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign m.valid = ~fifo_empty_s;
  assign m.data  = fifo_head_s;

  // A write in the commit cycle lands in the shadow bank before the swap.
  assign tap_ok_s  = tap_in_range(32'(cfg_addr), NUM_TAPS);
  assign wr_ok_s   = cfg_we & ~busy_s & tap_ok_s;
  assign err_set_s = (cfg_we & (busy_s | ~tap_ok_s)) | (cfg_commit & busy_s);

  // Shadow writes and the all-taps-at-once swap into the active bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_r[k] <= '0;
        active_r[k] <= '0;
      end
    end else begin
      if (wr_ok_s) begin
        shadow_r[cfg_addr] <= cfg_data;
      end
      if (swap_s) begin
        active_r <= shadow_r;
      end
    end
  end

  // Flatten the active bank onto the filter coefficient bus.
  always_comb begin
    f_coeff = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      f_coeff[k*DATA_W +: DATA_W] = active_r[k];
    end
  end

  // Sticky configuration error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end
  end

  assign cfg_err = err_r;

  // Accepted-sample counter; in flush builds it restarts with the new bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 32'd0;
`ifdef FIR_CTRL_FLUSH_EN
    end else if (swap_s) begin
      cnt_r <= 32'd0;
`endif
    end else if (accept_s) begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  assign sample_cnt = cnt_r;

`ifdef FIR_CTRL_FLUSH_EN
  assign f_clr = swap_s;
`else
  assign f_clr = 1'b0;
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: self-checking bench for fir_ctrl with a stub filter
// (f_y = f_x sign-extended, delayed LATENCY cycles). A behavioural model
// tracks accepted-but-undelivered samples, the coefficient banks and the
// drain/swap sequence, and is compared against the DUT every cycle.
module tb_fir_ctrl;

  localparam int NUM_TAPS   = fir_pkg::NUM_TAPS;
  localparam int DATA_W     = fir_pkg::DATA_W;
  localparam int OUT_W      = fir_pkg::OUT_W;
  localparam int LATENCY    = fir_pkg::LATENCY;
  localparam int OBUF_DEPTH = fir_pkg::OBUF_DEPTH;
  localparam int ADDR_W     = $clog2(NUM_TAPS);

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_SWAP  = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       f_ce;
  logic [DATA_W-1:0]          f_x;
  logic [NUM_TAPS*DATA_W-1:0] f_coeff;
  logic [OUT_W-1:0]           f_y;
  logic                       f_clr;
  logic                       cfg_we = 1'b0;
  logic [ADDR_W-1:0]          cfg_addr = '0;
  logic [DATA_W-1:0]          cfg_data = '0;
  logic                       cfg_commit = 1'b0;
  logic                       cfg_busy;
  logic                       cfg_err;
  logic [31:0]                sample_cnt;

  fir_ctrl_if #(.W(DATA_W)) s_if ();
  fir_ctrl_if #(.W(OUT_W))  m_if ();

  fir_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s_if),
    .m          (m_if),
    .f_ce       (f_ce),
    .f_x        (f_x),
    .f_coeff    (f_coeff),
    .f_y        (f_y),
    .f_clr      (f_clr),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .cfg_err    (cfg_err),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  // Stub filter: pure delay line of the sample bus.
  logic [DATA_W-1:0] dly [LATENCY];
  always @(posedge clk) begin
    dly[0] <= f_x;
    for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
  end

  function automatic logic [OUT_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign f_y = sext(dly[LATENCY-1]);

  // Model state
  typedef struct {
    logic [DATA_W-1:0] val;
    int                acc;
  } pend_t;

  pend_t             pend_q[$];
  int                mode;
  int                cyc;
  logic [31:0]       cnt_m;
  bit                err_m;
  logic [DATA_W-1:0] shadow_m [NUM_TAPS];
  logic [DATA_W-1:0] active_m [NUM_TAPS];

  // Observation logs
  logic [DATA_W-1:0] acc_log[$];
  int                acc_cyc_log[$];
  logic [OUT_W-1:0]  got_log[$];
  int                got_cyc_log[$];
  int                clr_cnt;
  int                cyc_all;

  int n_tests;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_coeff(input string name);
    int bad;
    bad = -1;
    for (int k = NUM_TAPS - 1; k >= 0; k--) begin
      if (f_coeff[k*DATA_W +: DATA_W] !== active_m[k]) bad = k;
    end
    if (bad < 0) check(name, 64'(f_coeff[DATA_W-1:0]), 64'(active_m[0]));
    else check($sformatf("%s tap %0d", name, bad), 64'(f_coeff[bad*DATA_W +: DATA_W]), 64'(active_m[bad]));
  endtask

  function automatic int inflight_m();
    int n;
    n = 0;
    foreach (pend_q[i]) if (pend_q[i].acc >= cyc - LATENCY) n++;
    return n;
  endfunction

  // One cycle of compare-then-update, evaluated at the falling edge.
  task automatic model_cycle();
    bit               exp_ready, exp_ce, exp_mv;
    int               next_mode;
    int               infl;
    if (f_ce) begin acc_log.push_back(f_x); acc_cyc_log.push_back(cyc_all); end
    if (m_if.valid && m_if.ready) begin got_log.push_back(m_if.data); got_cyc_log.push_back(cyc_all); end
    if (f_clr) clr_cnt++;
    cyc_all++;
    if (rst) begin
      pend_q.delete();
      mode  = M_RUN;
      cyc   = 0;
      cnt_m = 32'd0;
      err_m = 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin shadow_m[k] = '0; active_m[k] = '0; end
      check("reset s_ready", 64'(s_if.ready), 64'd1);
      check("reset m_valid", 64'(m_if.valid), 64'd0);
      check("reset cfg_busy", 64'(cfg_busy), 64'd0);
      check("reset cfg_err", 64'(cfg_err), 64'd0);
      check("reset f_clr", 64'(f_clr), 64'd0);
      check("reset sample_cnt", 64'(sample_cnt), 64'd0);
      check_coeff("reset f_coeff");
      return;
    end
    exp_ready = (mode == M_RUN) && (pend_q.size() < OBUF_DEPTH);
    exp_ce    = exp_ready && s_if.valid;
    exp_mv    = (pend_q.size() > 0) && (pend_q[0].acc + LATENCY + 1 <= cyc);
    check("s_ready", 64'(s_if.ready), 64'(exp_ready));
    check("f_ce", 64'(f_ce), 64'(exp_ce));
    check("f_x", 64'(f_x), 64'(s_if.data));
    check("m_valid", 64'(m_if.valid), 64'(exp_mv));
    if (exp_mv) check("m_data", m_if.data, sext(pend_q[0].val));
    check("cfg_busy", 64'(cfg_busy), 64'(mode != M_RUN));
    check("cfg_err", 64'(cfg_err), 64'(err_m));
    check("sample_cnt", 64'(sample_cnt), 64'(cnt_m));
`ifdef FIR_CTRL_FLUSH_EN
    check("f_clr", 64'(f_clr), 64'(mode == M_SWAP));
`else
    check("f_clr", 64'(f_clr), 64'd0);
`endif
    check_coeff("f_coeff");

    next_mode = mode;
    infl = inflight_m();
    if (mode == M_RUN) begin
      if (cfg_we) begin
        if (int'(cfg_addr) < NUM_TAPS) shadow_m[cfg_addr] = cfg_data;
        else err_m = 1'b1;
      end
      if (cfg_commit) next_mode = M_DRAIN;
    end else begin
      if (cfg_we || cfg_commit) err_m = 1'b1;
      if (mode == M_DRAIN && infl == 0) next_mode = M_SWAP;
      if (mode == M_SWAP) begin
        for (int k = 0; k < NUM_TAPS; k++) active_m[k] = shadow_m[k];
`ifdef FIR_CTRL_FLUSH_EN
        cnt_m = 32'd0;
`endif
        next_mode = M_RUN;
      end
    end
    if (exp_mv && m_if.ready) void'(pend_q.pop_front());
    if (exp_ce) begin
      pend_q.push_back('{val: s_if.data, acc: cyc});
      cnt_m++;
    end
    mode = next_mode;
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  int base_a, base_g, base_c, busy_cycles;
  logic [31:0] cnt_before;

  initial begin
    n_tests = 0; n_fail = 0; clr_cnt = 0; cyc_all = 0;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("post-reset s_ready", 64'(s_if.ready), 64'd1);
    check("post-reset sample_cnt", 64'(sample_cnt), 64'd0);

    // Stream 1..8 with the sink always ready.
    base_a = acc_log.size(); base_g = got_log.size();
    m_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_if.valid = 1'b1; s_if.data = DATA_W'(i);
      tick();
    end
    s_if.valid = 1'b0;
    repeat (6) tick();
    check("t1 results delivered", 64'(got_log.size() - base_g), 64'd8);
    for (int i = 0; i < 8 && base_g + i < got_log.size(); i++)
      check($sformatf("t1 m_data[%0d]", i), got_log[base_g + i], 64'(i + 1));
    if (got_log.size() > base_g && acc_log.size() > base_a)
      check("t1 first latency", 64'(got_cyc_log[base_g] - acc_cyc_log[base_a]), 64'd3);
    else check("t1 first latency", 64'd0, 64'd3);
    check("t1 sample_cnt", 64'(sample_cnt), 64'd8);

    // Backpressure: exactly OBUF_DEPTH accepts, then full recovery.
    base_a = acc_log.size(); base_g = got_log.size();
    m_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_if.valid = 1'b1; s_if.data = $urandom;
      tick();
    end
    check("t2 accepts before stall", 64'(acc_log.size() - base_a), 64'(OBUF_DEPTH));
    check("t2 s_ready low", 64'(s_if.ready), 64'd0);
    s_if.valid = 1'b0; m_if.ready = 1'b1;
    repeat (8) tick();
    check("t2 delivered", 64'(got_log.size() - base_g), 64'(OBUF_DEPTH));
    for (int i = 0; i < OBUF_DEPTH && base_g + i < got_log.size() && base_a + i < acc_log.size(); i++)
      check($sformatf("t2 value[%0d]", i), got_log[base_g + i], sext(acc_log[base_a + i]));

    // Shadow write then commit in the middle of a stream.
    base_c = clr_cnt;
    for (int i = 0; i < 6; i++) begin
      s_if.valid = 1'b1; s_if.data = $urandom;
      if (i == 3) begin cfg_we = 1'b1; cfg_addr = '0; cfg_data = 32'h7FFFFFFF; end
      else cfg_we = 1'b0;
      tick();
    end
    cfg_we = 1'b0; cfg_commit = 1'b1; s_if.data = $urandom;
    tick();
    cfg_commit = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 30 && cfg_busy; i++) begin
      busy_cycles++; s_if.data = $urandom;
      tick();
    end
    check("t3 swap completes", 64'(cfg_busy), 64'd0);
    check("t3 busy cycles", 64'(busy_cycles), 64'd4);
    check("t3 f_coeff tap0", 64'(f_coeff[DATA_W-1:0]), 64'h7FFFFFFF);
`ifdef FIR_CTRL_FLUSH_EN
    check("t3 sample_cnt flushed", 64'(sample_cnt), 64'd0);
    check("t3 f_clr pulses", 64'(clr_cnt - base_c), 64'd1);
`else
    check("t3 sample_cnt continues", 64'(sample_cnt), 64'd19);
    check("t3 f_clr quiet", 64'(clr_cnt - base_c), 64'd0);
`endif
    s_if.valid = 1'b0;

    // Bad address, then a second commit during DRAIN.
    cfg_we = 1'b1; cfg_addr = ADDR_W'(NUM_TAPS); cfg_data = 32'h12345678;
    tick();
    cfg_we = 1'b0;
    check("t4 cfg_err on bad addr", 64'(cfg_err), 64'd1);
    s_if.valid = 1'b1; s_if.data = $urandom; cfg_commit = 1'b1;
    tick();
    s_if.valid = 1'b0; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (8) tick();
    check("t4 cfg_err sticky", 64'(cfg_err), 64'd1);
    check("t4 busy cleared", 64'(cfg_busy), 64'd0);
    check("t4 tap0 kept", 64'(f_coeff[DATA_W-1:0]), 64'h7FFFFFFF);
    check("t4 tap38 untouched", 64'(f_coeff[38*DATA_W +: DATA_W]), 64'd0);

    // Randomised soak; tap 0 is left alone so the active bank stays nonzero.
    for (int i = 0; i < 150; i++) begin
      s_if.valid = ($urandom_range(0, 1) == 1);
      s_if.data  = $urandom;
      m_if.ready = ($urandom_range(0, 9) < 7);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_addr   = ADDR_W'($urandom_range(1, 127));
      cfg_data   = $urandom;
      cfg_commit = ($urandom_range(0, 15) == 0);
      tick();
    end
    s_if.valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; m_if.ready = 1'b1;
    repeat (12) tick();

    // Reset in the middle of DRAIN with three results buffered.
    m_if.ready = 1'b0;
    s_if.valid = 1'b1; s_if.data = $urandom; tick();
    s_if.data = $urandom; tick();
    s_if.data = $urandom; cfg_commit = 1'b1; tick();
    cfg_commit = 1'b0; s_if.valid = 1'b0;
    repeat (2) tick();
    check("t6 pre-reset busy", 64'(cfg_busy), 64'd1);
    check("t6 pre-reset m_valid", 64'(m_if.valid), 64'd1);
    check("t6 pre-reset f_coeff nonzero", 64'(f_coeff != '0), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("t6 rst m_valid", 64'(m_if.valid), 64'd0);
    check("t6 rst s_ready", 64'(s_if.ready), 64'd1);
    check("t6 rst cfg_busy", 64'(cfg_busy), 64'd0);
    check("t6 rst cfg_err", 64'(cfg_err), 64'd0);
    check("t6 rst f_coeff zero", 64'(f_coeff == '0), 64'd1);
    tick();
    rst = 1'b0;
    m_if.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.valid = 1'b1; s_if.data = $urandom; tick();
    end
    s_if.valid = 1'b0;
    repeat (6) tick();
    check("final sample_cnt", 64'(sample_cnt), 64'd3);
`ifndef FIR_CTRL_FLUSH_EN
    check("f_clr never asserted", 64'(clr_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
